fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 ENTRIES, default 4, number of direct-mapped one-word instruction buffer entries; power of two, 2..16.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 pc  input  32  current fetch address from the PC register; pc[1:0] ignored.
REQ-006 flush  input  1  redirect; discards the current fetch.
REQ-007 instr  output  32  fetched instruction word.
REQ-008 instr_valid  output  1  instr is the word at pc this cycle.
REQ-009 stall_fetch  output  1  PC register holds its value while high.
REQ-010 mem_req  output  1  read request to the shared instruction-memory arbiter.
REQ-011 mem_addr  output  32  word-aligned request address.
REQ-012 mem_gnt  input  1  arbiter accepts the request this cycle.
REQ-013 mem_rvalid  input  1  read data returned this cycle.
REQ-014 mem_rdata  input  32  returned read data.

Function
REQ-015 Index SHALL be pc[2+IW-1:2] with IW = log2(ENTRIES); tag SHALL be pc[31:2+IW]; each entry SHALL hold a valid bit, a tag and a 32-bit word.
REQ-016 The FSM SHALL have the states LOOKUP, REQ, WAIT and DROP.
REQ-017 LOOKUP, hit, flush=0: combinationally instr = entry word, instr_valid=1, stall_fetch=0.
REQ-018 LOOKUP, miss, flush=0: stall_fetch=1, instr_valid=0, {pc[31:2],2'b00} latched into mem_addr, next state REQ.
REQ-019 LOOKUP, flush=1: instr_valid=0, stall_fetch=0, state stays LOOKUP, no request.
REQ-020 REQ: mem_req=1, mem_addr stable; on mem_gnt go to WAIT, otherwise hold; mem_req SHALL NOT drop until granted unless flush=1.
REQ-021 REQ, flush=1, mem_gnt=0: mem_req deasserted next cycle, return to LOOKUP.
REQ-022 REQ, flush=1, mem_gnt=1: go to DROP (the request is accepted and must be drained).
REQ-023 WAIT: mem_req=0; on mem_rvalid write mem_rdata, tag and valid=1 into the indexed entry for the latched address, then go to LOOKUP; the instruction is delivered on the following cycle via a hit.
REQ-024 WAIT, flush=1: go to DROP; if mem_rvalid is high in the same cycle, the data SHALL be discarded (no fill) and the next state SHALL be LOOKUP.
REQ-025 DROP: mem_req=0; on mem_rvalid discard the data and go to LOOKUP.
REQ-026 stall_fetch SHALL be 1 in REQ, WAIT and DROP and instr_valid SHALL be 0 in those states.
REQ-027 mem_rvalid in LOOKUP or REQ SHALL be ignored; at most one request SHALL be outstanding.
REQ-028 A fill SHALL overwrite the indexed entry unconditionally; there is no eviction tracking.
REQ-029 Best-case miss latency: miss in LOOKUP at cycle 0, REQ at cycle 1 (granted), rvalid at cycle 2, hit with instr_valid=1 at cycle 3.

Reset
REQ-030 On reset: all valid bits = 0, state = LOOKUP, mem_req = 0, mem_addr = 0; instr_valid = 0 and stall_fetch = 1 in the first cycle after reset if pc misses.
REQ-031 Reset SHALL take priority over flush and over all handshake inputs; a reset in WAIT or DROP abandons the outstanding read, and the stray mem_rvalid that follows SHALL be ignored in LOOKUP.
REQ-032 Tag and data arrays need no reset.

Verification
REQ-033 After reset, pc=0x100 with gnt after 2 cycles and rvalid 1 cycle later carrying 0xDEADBEEF -> stall high for 4 cycles, then instr=0xDEADBEEF, instr_valid=1; a repeat of pc=0x100 hits with zero stall.
REQ-034 Conflict: fill 0x100, then pc=0x110 (same index, ENTRIES=4) -> miss and refill; a return to 0x100 misses again.
REQ-035 Flush in REQ without gnt -> mem_req low next cycle, LOOKUP, no fill; a flush coinciding with gnt -> DROP, the rvalid data 0x12345678 is not written and a later lookup of that pc misses.
REQ-036 Flush in WAIT, rvalid 3 cycles later -> stall stays high until rvalid, no fill, then LOOKUP.
REQ-037 Reset in WAIT, then rvalid=1 with 0xCAFEF00D on the next cycle -> ignored; all entries invalid and pc=0x200 misses.
REQ-038 Hold mem_gnt=0 for 10 cycles in REQ -> mem_req and mem_addr stable throughout, stall_fetch=1.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: a direct-mapped, one-word-per-entry instruction buffer in front of a
// shared instruction-memory arbiter. A hit delivers the word combinationally. A miss stalls the
// PC, issues a single read, fills the entry and then retries the lookup.
module fetch_unit #(
    parameter int unsigned ENTRIES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_i,
    input  logic        flush_i,
    output logic [31:0] instr_o,
    output logic        instr_valid_o,
    output logic        stall_fetch_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int unsigned IW = $clog2(ENTRIES);
    localparam int unsigned TW = 30 - IW;

    typedef enum logic [1:0] {
        StLookup,
        StReq,
        StWait,
        StDrop
    } state_e;

    state_e state_q, state_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TW-1:0] tag_q [ENTRIES];
    logic [31:0] data_q [ENTRIES];

    logic [IW-1:0] lu_idx;
    logic [TW-1:0] lu_tag;
    logic [IW-1:0] fill_idx;
    logic [TW-1:0] fill_tag;
    logic          hit;
    logic          fill_en;

    // Byte offset of the PC carries no information for word fetches.
    logic unused_pc;
    assign unused_pc = ^pc_i[1:0];

    assign lu_idx   = pc_i[2 +: IW];
    assign lu_tag   = pc_i[31 -: TW];
    assign fill_idx = mem_addr_q[2 +: IW];
    assign fill_tag = mem_addr_q[31 -: TW];
    assign hit      = valid_q[lu_idx] && (tag_q[lu_idx] == lu_tag);

    assign mem_addr_o = mem_addr_q;

    // Next-state, request/stall outputs and fill enable.
    always_comb begin
        state_d       = state_q;
        mem_addr_d    = mem_addr_q;
        fill_en       = 1'b0;
        instr_o       = data_q[lu_idx];
        instr_valid_o = 1'b0;
        stall_fetch_o = 1'b1;
        mem_req_o     = 1'b0;
        unique case (state_q)
            StLookup: begin
                if (flush_i) begin
                    stall_fetch_o = 1'b0;
                end else if (hit) begin
                    instr_valid_o = 1'b1;
                    stall_fetch_o = 1'b0;
                end else begin
                    mem_addr_d = {pc_i[31:2], 2'b00};
                    state_d    = StReq;
                end
            end
            StReq: begin
                mem_req_o = 1'b1;
                // An accepted request must be drained even when flushed.
                if (mem_gnt_i) begin
                    state_d = flush_i ? StDrop : StWait;
                end else if (flush_i) begin
                    state_d = StLookup;
                end
            end
            StWait: begin
                if (flush_i) begin
                    state_d = mem_rvalid_i ? StLookup : StDrop;
                end else if (mem_rvalid_i) begin
                    fill_en = 1'b1;
                    state_d = StLookup;
                end
            end
            StDrop: begin
                if (mem_rvalid_i) begin
                    state_d = StLookup;
                end
            end
            default: begin
                state_d = StLookup;
            end
        endcase
    end

    // Valid bits: set on fill, cleared only by reset.
    always_comb begin
        valid_d = valid_q;
        if (fill_en) begin
            valid_d[fill_idx] = 1'b1;
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StLookup;
            mem_addr_q <= '0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            valid_q    <= valid_d;
        end
    end

    // Tag and data arrays; contents are qualified by valid_q so they carry no reset.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= mem_rdata_i;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit (ENTRIES = 4): hits, misses, conflicts, flushes and resets.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        flush;
    logic [31:0] instr;
    logic        instr_valid;
    logic        stall_fetch;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_unit #(.ENTRIES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .pc_i         (pc),
        .flush_i      (flush),
        .instr_o      (instr),
        .instr_valid_o(instr_valid),
        .stall_fetch_o(stall_fetch),
        .mem_req_o    (mem_req),
        .mem_addr_o   (mem_addr),
        .mem_gnt_i    (mem_gnt),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Best-case miss/fill: LOOKUP miss, REQ granted, WAIT with rvalid; ends in LOOKUP.
    task automatic fill(input logic [31:0] p, input logic [31:0] d);
        pc = p;
        #1;
        tick();
        mem_gnt = 1'b1;
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = d;
        tick();
        mem_rvalid = 1'b0;
        #1;
    endtask

    task automatic expect_hit(input string tag, input logic [31:0] d);
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
        chk({tag, "_stall"}, {31'd0, stall_fetch}, 32'd0);
        chk({tag, "_instr"}, instr, d);
    endtask

    task automatic expect_miss(input string tag);
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, "_stall"}, {31'd0, stall_fetch}, 32'd1);
    endtask

    initial begin
        reset      = 1'b1;
        pc         = 32'h0;
        flush      = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        tick();
        tick();

        // Reset state.
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        expect_miss("rst");

        // Miss at 0x100, grant after 2 cycles, rvalid one cycle later.
        reset = 1'b0;
        pc    = 32'h100;
        #1;
        expect_miss("m0");
        chk("m0_req", {31'd0, mem_req}, 32'd0);
        tick();
        chk("m1_req", {31'd0, mem_req}, 32'd1);
        chk("m1_addr", mem_addr, 32'h100);
        chk("m1_stall", {31'd0, stall_fetch}, 32'd1);
        tick();
        mem_gnt = 1'b1;
        #1;
        chk("m2_req", {31'd0, mem_req}, 32'd1);
        chk("m2_stall", {31'd0, stall_fetch}, 32'd1);
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEADBEEF;
        #1;
        chk("m3_req", {31'd0, mem_req}, 32'd0);
        expect_miss("m3");
        tick();
        mem_rvalid = 1'b0;
        #1;
        expect_hit("m4", 32'hDEADBEEF);
        tick();
        expect_hit("m5", 32'hDEADBEEF);

        // Conflict: 0x110 shares index 0 with 0x100.
        pc = 32'h110;
        #1;
        expect_miss("cf0");
        fill(32'h110, 32'h11111111);
        expect_hit("cf1", 32'h11111111);
        pc = 32'h100;
        #1;
        expect_miss("cf2");
        fill(32'h100, 32'hDEADBEEF);
        expect_hit("cf3", 32'hDEADBEEF);

        // Flush in REQ without grant.
        pc = 32'h204;
        #1;
        expect_miss("fr0");
        tick();
        flush = 1'b1;
        #1;
        chk("fr1_req", {31'd0, mem_req}, 32'd1);
        tick();
        chk("fr2_req", {31'd0, mem_req}, 32'd0);
        chk("fr2_stall", {31'd0, stall_fetch}, 32'd0);
        chk("fr2_valid", {31'd0, instr_valid}, 32'd0);
        flush = 1'b0;
        pc    = 32'h100;
        #1;
        expect_hit("fr3", 32'hDEADBEEF);

        // Flush coinciding with grant: DROP, data discarded.
        pc = 32'h208;
        #1;
        tick();
        flush   = 1'b1;
        mem_gnt = 1'b1;
        tick();
        flush   = 1'b0;
        mem_gnt = 1'b0;
        pc      = 32'h100;
        #1;
        chk("fg0_req", {31'd0, mem_req}, 32'd0);
        expect_miss("fg0");
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h12345678;
        #1;
        expect_miss("fg1");
        tick();
        mem_rvalid = 1'b0;
        pc         = 32'h208;
        #1;
        expect_miss("fg2");
        fill(32'h208, 32'hAAAA0208);
        expect_hit("fg3", 32'hAAAA0208);

        // Flush in WAIT together with rvalid: no fill, straight back to LOOKUP.
        pc = 32'h20C;
        #1;
        tick();
        mem_gnt = 1'b1;
        tick();
        mem_gnt    = 1'b0;
        flush      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h55555555;
        tick();
        flush      = 1'b0;
        mem_rvalid = 1'b0;
        pc         = 32'h100;
        #1;
        expect_hit("fwr0", 32'hDEADBEEF);
        pc = 32'h20C;
        #1;
        expect_miss("fwr1");
        fill(32'h20C, 32'hBBBB020C);
        expect_hit("fwr2", 32'hBBBB020C);

        // Flush in WAIT, rvalid three cycles later.
        pc = 32'h30C;
        #1;
        tick();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        flush   = 1'b1;
        #1;
        expect_miss("fw0");
        tick();
        flush = 1'b0;
        pc    = 32'h100;
        #1;
        expect_miss("fw1");
        tick();
        expect_miss("fw2");
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCCCCCCCC;
        #1;
        expect_miss("fw3");
        tick();
        mem_rvalid = 1'b0;
        #1;
        expect_hit("fw4", 32'hDEADBEEF);
        pc = 32'h30C;
        #1;
        expect_miss("fw5");

        // Reset in WAIT, stray rvalid afterwards.
        tick();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        reset   = 1'b1;
        tick();
        reset      = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFEF00D;
        pc         = 32'h100;
        #1;
        chk("rw0_req", {31'd0, mem_req}, 32'd0);
        chk("rw0_addr", mem_addr, 32'h0);
        expect_miss("rw0");
        tick();
        mem_rvalid = 1'b0;
        flush      = 1'b1;
        #1;
        chk("rw1_req", {31'd0, mem_req}, 32'd1);
        tick();
        flush = 1'b0;
        pc    = 32'h200;
        #1;
        expect_miss("rw2");

        // Grant held off for 10 cycles in REQ.
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("hold_req", {31'd0, mem_req}, 32'd1);
            chk("hold_addr", mem_addr, 32'h200);
            chk("hold_stall", {31'd0, stall_fetch}, 32'd1);
            tick();
        end
        mem_gnt = 1'b1;
        #1;
        chk("hold_gnt_req", {31'd0, mem_req}, 32'd1);
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBEEF0200;
        tick();
        mem_rvalid = 1'b0;
        #1;
        expect_hit("hold_end", 32'hBEEF0200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
